// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a small MIPS-style subset.
// Define MC_CTRL_PERF_EN to add the cycle_cnt/instr_cnt counters.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [4:0]  aluop,
  output logic        alu_src,
  output logic        if_extend,
  output logic [1:0]  reg_dst,
  output logic [1:0]  memtoreg,
  output logic [1:0]  s_npc,
  output logic [2:0]  state,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100,
    S_ERR = 3'b101
  } state_e;

  localparam logic [4:0] A_ADD  = 5'b00000;
  localparam logic [4:0] A_ADDU = 5'b00001;
  localparam logic [4:0] A_SUBU = 5'b00010;
  localparam logic [4:0] A_AND  = 5'b00011;
  localparam logic [4:0] A_OR   = 5'b00100;
  localparam logic [4:0] A_SLT  = 5'b00101;
  localparam logic [4:0] A_LUI  = 5'b00110;
  localparam logic [4:0] A_NONE = 5'b11111;

  state_e state_q, state_d;
  logic   run_q;

  logic       is_rt, is_jr, is_imm;
  logic       is_lw, is_sw, is_beq;
  logic       is_j, is_jal, legal;
  logic       dec_ext;
  logic [4:0] dec_alu;

  // op/funct stay stable for the whole instruction, so decode live
  always_comb begin
    is_rt   = 1'b0;
    is_jr   = 1'b0;
    is_imm  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    dec_ext = 1'b0;
    dec_alu = A_NONE;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin is_rt = 1'b1; dec_alu = A_ADD;  end
          6'h21: begin is_rt = 1'b1; dec_alu = A_ADDU; end
          6'h23: begin is_rt = 1'b1; dec_alu = A_SUBU; end
          6'h24: begin is_rt = 1'b1; dec_alu = A_AND;  end
          6'h25: begin is_rt = 1'b1; dec_alu = A_OR;   end
          6'h2a: begin is_rt = 1'b1; dec_alu = A_SLT;  end
          6'h08: is_jr = 1'b1;
          default: ;
        endcase
      end
      6'h08: begin
        is_imm = 1'b1; dec_alu = A_ADD; dec_ext = 1'b1;
      end
      6'h09: begin
        is_imm = 1'b1; dec_alu = A_ADDU; dec_ext = 1'b1;
      end
      6'h0c: begin is_imm = 1'b1; dec_alu = A_AND; end
      6'h0d: begin is_imm = 1'b1; dec_alu = A_OR;  end
      6'h0f: begin is_imm = 1'b1; dec_alu = A_LUI; end
      6'h23: begin
        is_lw = 1'b1; dec_alu = A_ADDU; dec_ext = 1'b1;
      end
      6'h2b: begin
        is_sw = 1'b1; dec_alu = A_ADDU; dec_ext = 1'b1;
      end
      6'h04: begin is_beq = 1'b1; dec_alu = A_SUBU; end
      6'h02: is_j   = 1'b1;
      6'h03: is_jal = 1'b1;
      default: ;
    endcase
    legal = is_rt | is_jr | is_imm | is_lw | is_sw
          | is_beq | is_j | is_jal;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    aluop     = A_NONE;
    alu_src   = 1'b0;
    if_extend = 1'b0;
    reg_dst   = 2'b00;
    memtoreg  = 2'b00;
    s_npc     = 2'b11;
    unique case (state_q)
      S_IF: begin
        // run_q holds off the first fetch until one edge after reset
        if (run_q) begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_ID;
          end
        end
      end
      S_ID: begin
        unique case (1'b1)
          !legal: state_d = S_ERR;
          is_j: begin
            pc_write = 1'b1;
            s_npc    = 2'b01;
            state_d  = S_IF;
          end
          is_jal: begin
            pc_write  = 1'b1;
            s_npc     = 2'b01;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            state_d   = S_IF;
          end
          is_jr: begin
            pc_write = 1'b1;
            s_npc    = 2'b10;
            state_d  = S_IF;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        aluop     = dec_alu;
        alu_src   = is_imm | is_lw | is_sw;
        if_extend = dec_ext;
        unique case (1'b1)
          is_beq: begin
            pc_write = zero;
            s_npc    = 2'b00;
            state_d  = S_IF;
          end
          is_lw | is_sw: state_d = S_MEM;
          default:       state_d = S_WB;
        endcase
      end
      S_MEM: begin
        aluop     = dec_alu;
        alu_src   = 1'b1;
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) state_d = is_lw ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write = 1'b1;
        memtoreg  = is_lw ? 2'b10 : 2'b01;
        reg_dst   = is_rt ? 2'b01 : 2'b00;
        state_d   = S_IF;
      end
      S_ERR: ;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  assign state   = state_q;
  assign illegal = (state_q == S_ERR);

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      if (state_q != S_ERR) cyc_q <= cyc_q + 32'd1;
      if (state_d == S_IF && state_q != S_IF)
        ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and randomized checks of mc_ctrl
// against a per-instruction behavioural model.
module tb_mc_ctrl;

  logic       clk, rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_read, mem_write, iord;
  logic       ir_write, pc_write, reg_write;
  logic [4:0] aluop;
  logic       alu_src, if_extend;
  logic [1:0] reg_dst, memtoreg, s_npc;
  logic [2:0] state;
  logic       illegal;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .aluop(aluop),
    .alu_src(alu_src), .if_extend(if_extend),
    .reg_dst(reg_dst), .memtoreg(memtoreg),
    .s_npc(s_npc), .state(state), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int C_R = 0, C_IMM = 1, C_LW = 2, C_SW = 3;
  localparam int C_BEQ = 4, C_J = 5, C_JAL = 6, C_JR = 7;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cls;
    logic [4:0] alu;
    logic       ext;
  } ins_t;

  ins_t tab [17];
  int   n_cmp = 0, n_bad = 0;
  int   edges;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  int          r_cyc, r_rw, r_pcw, r_irw, r_mreq, r_mr, r_mw;
  int          r_iord, r_viol, r_both;
  logic [63:0] r_seq;
  logic [1:0]  r_rdst, r_m2r, r_npc;
  logic [4:0]  r_exalu;
  logic        r_exsrc, r_exext, r_to;

  int          e_cyc, e_rw, e_pcw, e_mreq, e_mr, e_mw;
  logic [63:0] e_seq;
  logic [1:0]  e_rdst, e_m2r, e_npc;

  function automatic ins_t mk(logic [5:0] o, logic [5:0] f,
                              int c, logic [4:0] a, logic x);
    ins_t t;
    t.op = o; t.fn = f; t.cls = c; t.alu = a; t.ext = x;
    return t;
  endfunction

  task automatic fill_tab();
    tab[0]  = mk(6'h00, 6'h20, C_R,   5'b00000, 1'b0);
    tab[1]  = mk(6'h00, 6'h21, C_R,   5'b00001, 1'b0);
    tab[2]  = mk(6'h00, 6'h23, C_R,   5'b00010, 1'b0);
    tab[3]  = mk(6'h00, 6'h24, C_R,   5'b00011, 1'b0);
    tab[4]  = mk(6'h00, 6'h25, C_R,   5'b00100, 1'b0);
    tab[5]  = mk(6'h00, 6'h2a, C_R,   5'b00101, 1'b0);
    tab[6]  = mk(6'h00, 6'h08, C_JR,  5'b11111, 1'b0);
    tab[7]  = mk(6'h08, 6'h15, C_IMM, 5'b00000, 1'b1);
    tab[8]  = mk(6'h09, 6'h3a, C_IMM, 5'b00001, 1'b1);
    tab[9]  = mk(6'h0c, 6'h07, C_IMM, 5'b00011, 1'b0);
    tab[10] = mk(6'h0d, 6'h00, C_IMM, 5'b00100, 1'b0);
    tab[11] = mk(6'h0f, 6'h11, C_IMM, 5'b00110, 1'b0);
    tab[12] = mk(6'h23, 6'h04, C_LW,  5'b00001, 1'b1);
    tab[13] = mk(6'h2b, 6'h09, C_SW,  5'b00001, 1'b1);
    tab[14] = mk(6'h04, 6'h2a, C_BEQ, 5'b00010, 1'b0);
    tab[15] = mk(6'h02, 6'h1f, C_J,   5'b11111, 1'b0);
    tab[16] = mk(6'h03, 6'h21, C_JAL, 5'b11111, 1'b0);
  endtask

  // Expected per-instruction trace summary from the rules
  task automatic model(input int k, input logic z,
                       input int iw, input int mw);
    int c;
    c = tab[k].cls;
    e_seq = '0;
    for (int i = 0; i <= iw; i++) e_seq = {e_seq[60:0], 3'd0};
    e_seq = {e_seq[60:0], 3'd1};
    if (c == C_R || c == C_IMM || c == C_LW ||
        c == C_SW || c == C_BEQ)
      e_seq = {e_seq[60:0], 3'd2};
    if (c == C_LW || c == C_SW)
      for (int i = 0; i <= mw; i++) e_seq = {e_seq[60:0], 3'd3};
    if (c == C_R || c == C_IMM || c == C_LW)
      e_seq = {e_seq[60:0], 3'd4};
    e_cyc = iw + 2;
    if (c == C_BEQ) e_cyc += 1;
    if (c == C_R || c == C_IMM) e_cyc += 2;
    if (c == C_SW) e_cyc += 2 + mw;
    if (c == C_LW) e_cyc += 3 + mw;
    e_rw = (c == C_R || c == C_IMM || c == C_LW ||
            c == C_JAL) ? 1 : 0;
    e_rdst = (c == C_R) ? 2'b01 : (c == C_JAL) ? 2'b10 : 2'b00;
    e_m2r  = (c == C_LW) ? 2'b10 : (c == C_JAL) ? 2'b00 : 2'b01;
    e_pcw = 1;
    e_npc = 2'b11;
    if (c == C_J || c == C_JAL) begin e_pcw = 2; e_npc = 2'b01; end
    if (c == C_JR) begin e_pcw = 2; e_npc = 2'b10; end
    if (c == C_BEQ && z) begin e_pcw = 2; e_npc = 2'b00; end
    e_mr   = iw + 1 + ((c == C_LW) ? mw + 1 : 0);
    e_mw   = (c == C_SW) ? mw + 1 : 0;
    e_mreq = iw + 1 + ((c == C_LW || c == C_SW) ? mw + 1 : 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Runs one instruction from IF back to the next IF
  task automatic run(input int k, input logic z,
                     input int iw, input int mw);
    int  waited;
    bit  left, done;
    op = tab[k].op; funct = tab[k].fn; zero = z;
    r_cyc = 0; r_rw = 0; r_pcw = 0; r_irw = 0; r_mreq = 0;
    r_mr = 0; r_mw = 0; r_iord = 0; r_viol = 0; r_both = 0;
    r_seq = '0; r_rdst = 2'b11; r_m2r = 2'b11; r_npc = 2'b11;
    r_exalu = 5'b11111; r_exsrc = 1'bx; r_exext = 1'bx;
    waited = 0; left = 0; done = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (left && state == 3'd0) begin done = 1; break; end
      if (state != 3'd0) left = 1;
      mem_ready = mem_req && (waited == (iord ? mw : iw));
      if (mem_req) waited = mem_ready ? 0 : waited + 1;
      #1;
      r_cyc++;
      r_seq = {r_seq[60:0], state};
      if (reg_write) begin
        r_rw++; r_rdst = reg_dst; r_m2r = memtoreg;
      end
      if (pc_write) begin
        r_pcw++;
        if (!ir_write) r_npc = s_npc;
      end
      if (pc_write && reg_write) r_both++;
      if (ir_write) r_irw++;
      if (mem_req) r_mreq++;
      if (mem_read) r_mr++;
      if (mem_write) r_mw++;
      if (iord) r_iord++;
      if ((mem_read | mem_write | iord) && !mem_req) r_viol++;
      if (illegal) r_viol++;
      if (state == 3'd2) begin
        r_exalu = aluop; r_exsrc = alu_src; r_exext = if_extend;
      end
    end
    r_to = !done;
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    op = 6'h00; funct = 6'h21; zero = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({state, mem_req, mem_read, iord} !== 6'b000000) begin
      n_bad++;
      $display("FAIL rst_state: got %b want 000000",
               {state, mem_req, mem_read, iord});
    end
    n_cmp++;
    if ({aluop, s_npc} !== 7'b1111111) begin
      n_bad++;
      $display("FAIL rst_alu_npc: got %b want 1111111",
               {aluop, s_npc});
    end
    n_cmp++;
    if ({ir_write, pc_write, reg_write, mem_write,
         illegal, reg_dst, memtoreg} !== 9'd0) begin
      n_bad++;
      $display("FAIL rst_strobes: got %b want 0",
               {ir_write, pc_write, reg_write, mem_write,
                illegal, reg_dst, memtoreg});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release_pre_edge: mem_req %b want 0",
               mem_req);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({state, mem_req} !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_first_edge: got %b want 0001",
               {state, mem_req});
    end
  endtask

  task automatic test_addu();
    run(1, 1'b0, 0, 0);
    n_cmp++;
    if (r_to || r_seq !== 64'o0124 || r_cyc != 4) begin
      n_bad++;
      $display("FAIL addu_seq: got %o/%0d want 124/4",
               r_seq, r_cyc);
    end
    n_cmp++;
    if ({r_rw[3:0], r_rdst, r_m2r} !== 8'b0001_01_01) begin
      n_bad++;
      $display("FAIL addu_wb: got %b want 00010101",
               {r_rw[3:0], r_rdst, r_m2r});
    end
    n_cmp++;
    if (r_exalu !== 5'b00001 || r_exsrc !== 1'b0) begin
      n_bad++;
      $display("FAIL addu_ex: got %b/%b want 00001/0",
               r_exalu, r_exsrc);
    end
  endtask

  task automatic test_lw_wait();
    run(12, 1'b0, 0, 3);
    n_cmp++;
    if (r_to || r_cyc != 8 || r_iord != 4) begin
      n_bad++;
      $display("FAIL lw_wait: cyc %0d iord %0d want 8/4",
               r_cyc, r_iord);
    end
    n_cmp++;
    if (r_m2r !== 2'b10 || r_rw != 1 || r_mreq != 5) begin
      n_bad++;
      $display("FAIL lw_wb: m2r %b rw %0d mreq %0d want 10/1/5",
               r_m2r, r_rw, r_mreq);
    end
  endtask

  task automatic test_beq();
    run(14, 1'b0, 0, 0);
    n_cmp++;
    if (r_to || r_cyc != 3 || r_pcw != 1) begin
      n_bad++;
      $display("FAIL beq_nt: cyc %0d pcw %0d want 3/1",
               r_cyc, r_pcw);
    end
    run(14, 1'b1, 0, 0);
    n_cmp++;
    if (r_to || r_cyc != 3 || r_pcw != 2 || r_npc !== 2'b00) begin
      n_bad++;
      $display("FAIL beq_t: cyc %0d pcw %0d npc %b want 3/2/00",
               r_cyc, r_pcw, r_npc);
    end
  endtask

  task automatic test_jal();
    run(16, 1'b0, 0, 0);
    n_cmp++;
    if (r_to || r_cyc != 2 || r_both != 1) begin
      n_bad++;
      $display("FAIL jal_pulse: cyc %0d both %0d want 2/1",
               r_cyc, r_both);
    end
    n_cmp++;
    if ({r_rdst, r_m2r, r_npc} !== 6'b10_00_01) begin
      n_bad++;
      $display("FAIL jal_fields: got %b want 100001",
               {r_rdst, r_m2r, r_npc});
    end
  endtask

  task automatic test_random();
    int k, iw, mw, bad;
    logic z;
    do_reset();
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(16, 0);
      z  = 1'($urandom_range(1, 0));
      iw = $urandom_range(3, 0);
      mw = $urandom_range(3, 0);
      model(k, z, iw, mw);
      run(k, z, iw, mw);
      n_cmp++;
      if (r_to || r_seq !== e_seq || r_cyc != e_cyc) begin
        n_bad++;
        $display("FAIL rnd_seq k%0d: got %o/%0d want %o/%0d",
                 k, r_seq, r_cyc, e_seq, e_cyc);
      end
      n_cmp++;
      if (r_rw != e_rw ||
          (e_rw == 1 && {r_rdst, r_m2r} !== {e_rdst, e_m2r})) begin
        n_bad++;
        $display("FAIL rnd_wb k%0d: got %0d %b %b want %0d %b %b",
                 k, r_rw, r_rdst, r_m2r, e_rw, e_rdst, e_m2r);
      end
      n_cmp++;
      if (r_pcw != e_pcw || r_npc !== e_npc || r_irw != 1) begin
        n_bad++;
        $display("FAIL rnd_pc k%0d: got %0d %b want %0d %b",
                 k, r_pcw, r_npc, e_pcw, e_npc);
      end
      n_cmp++;
      if (r_mreq != e_mreq || r_mr != e_mr || r_mw != e_mw ||
          r_viol != 0) begin
        n_bad++;
        $display("FAIL rnd_mem k%0d: got %0d %0d %0d v%0d want %0d %0d %0d",
                 k, r_mreq, r_mr, r_mw, r_viol, e_mreq, e_mr, e_mw);
      end
      if (tab[k].cls == C_R || tab[k].cls == C_IMM ||
          tab[k].cls == C_BEQ) begin
        n_cmp++;
        if (r_exalu !== tab[k].alu || r_exext !== tab[k].ext ||
            r_exsrc !== (tab[k].cls == C_IMM)) begin
          n_bad++;
          $display("FAIL rnd_ex k%0d: got %b %b %b want %b %b",
                   k, r_exalu, r_exext, r_exsrc,
                   tab[k].alu, tab[k].ext);
        end
      end
    end
`ifdef MC_CTRL_PERF_EN
    n_cmp++;
    if (cycle_cnt !== 32'(edges) || instr_cnt !== 32'd60) begin
      n_bad++;
      $display("FAIL perf_cnt: got %0d/%0d want %0d/60",
               cycle_cnt, instr_cnt, edges);
    end
`endif
  endtask

  task automatic test_reset_mid_sw();
    int bad, guard;
    op = 6'h2b; funct = 6'h00; zero = 1'b0;
    guard = 0;
    while (state != 3'd3 && guard < 20) begin
      mem_ready = mem_req && !iord;
      @(negedge clk); #1;
      guard++;
    end
    mem_ready = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_cmp++;
    if (guard >= 20 || {mem_req, mem_write, iord} !== 3'b111) begin
      n_bad++;
      $display("FAIL sw_mem_wait: got %b want 111",
               {mem_req, mem_write, iord});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, mem_req, mem_write, iord} !== 6'd0) begin
      n_bad++;
      $display("FAIL sw_rst_async: got %b want 0",
               {state, mem_req, mem_write, iord});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(1, 0));
      @(negedge clk); #1;
      if (mem_req | mem_write | pc_write | reg_write | ir_write)
        bad++;
    end
`ifdef MC_CTRL_PERF_EN
    n_cmp++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL sw_rst_perf: got %0d/%0d want 0/0",
               cycle_cnt, instr_cnt);
    end
`endif
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    if (mem_req | mem_write) bad++;
    @(negedge clk); #1;
    if (mem_write || !mem_req || state != 3'd0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL sw_rst_quiet: bad cycles %0d want 0", bad);
    end
  endtask

  task automatic test_illegal();
    int bad;
    op = 6'h3f; funct = 6'h00;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state !== 3'd1 ||
        (pc_write | reg_write | ir_write | mem_req)) begin
      n_bad++;
      $display("FAIL ill_id: state %b strobes %b want 001/0",
               state, {pc_write, reg_write, ir_write, mem_req});
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      mem_ready = 1'($urandom_range(1, 0));
      zero = 1'($urandom_range(1, 0));
      #1;
      if (state != 3'd5 || !illegal) bad++;
      if (mem_req | mem_read | mem_write | iord | ir_write |
          pc_write | reg_write) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL ill_sticky: bad cycles %0d want 0", bad);
    end
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, illegal} !== 4'b0000) begin
      n_bad++;
      $display("FAIL ill_reset: got %b want 0000",
               {state, illegal});
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    fill_tab();
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_random();
    test_reset_mid_sw();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
